alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequencer between the instruction source and the execute datapath: the register file, the ALU (adder/subtractor, negate, logic gates, barrel shifters) and the 16x16 carry-save multiplier.
- Accepts one 32-bit instruction at a time via valid/ready and decodes opcode[31:26].
- Drives register-file reads, the ALU op select, multi-cycle multiply timing, data-memory accesses and register write-back.
- Strictly one instruction in flight (non-pipelined).

Parameters:
DATA_W, 16, datapath width
MUL_LAT, 4, cycles from mul_start to valid multiplier product (>=1)
AW, 8, data-memory address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction word
instr_valid  in  1  instr present
instr_ready  out  1  controller idle, can accept
rf_raddr_a  out  5  read port A address
rf_raddr_b  out  5  read port B address
rf_rdata_a  in  DATA_W  port A data, valid 1 cycle after address
rf_rdata_b  in  DATA_W  port B data, valid 1 cycle after address
rf_we  out  1  register write enable
rf_waddr  out  5  write address
rf_wdata  out  DATA_W  write data
alu_op  out  4  ALU function select
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_result  in  2*DATA_W  ALU/multiplier result; [DATA_W] = carry/borrow for add/sub
mul_start  out  1  one-cycle multiply start pulse
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_addr  out  AW  memory address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data, valid with ack
dmem_ack  in  1  access complete
busy  out  1  state != IDLE
illegal_op  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state IDLE; all registered outputs 0 (rf_we, mul_start, dmem_req, dmem_we, illegal_op, addresses, data, alu_op).
  - instr_ready = (state==IDLE), so it reads 1 during reset.
  - Reset mid-instruction aborts it. No partial write-back occurs after rst_n falls.
- States: IDLE, READ, EXEC, MEM, WB_LO, WB_HI.
- Accept: instr_valid & instr_ready at edge T latches instr. Fields:
  - op = [31:26], rd2 = [25:21], rd1 = [20:16], rs2 = [9:5], rs1 = [4:0]
  - imm = [15:0], ld_addr = [7:0], st_addr = [25:18]
- Opcodes:
  - 000000 LDI: IDLE->WB_LO; write rd2 <= imm at T+1.
  - 000001 MOV: read rs = [4:0] on port B; READ->WB_LO; rd2 <= rdata_b.
  - 000010 LD: IDLE->MEM; dmem_req=1, dmem_we=0, addr = ld_addr. On ack: MEM->WB_LO; rd2 <= dmem_rdata.
  - 000011 ST: READ port B = [4:0]; READ->MEM; dmem_we=1, addr = st_addr, wdata = rdata_b. On ack: IDLE, no rf write.
  - 000100 ADD, 000101 SUB: READ->EXEC (1 cycle)->WB_LO (rd1 <= result[15:0])->WB_HI (rd2 <= {15'b0, result[16]}).
  - 000110 NEG: alu_a = R[rs1]. EXEC 1 cycle; WB_LO only.
  - 000111 MUL: mul_start pulses on the first EXEC cycle. EXEC lasts exactly MUL_LAT cycles. Then WB_LO (rd1 <= product[15:0]) and WB_HI (rd2 <= product[31:16]).
  - 001000 AND, 001001 OR, 001010 NAND, 001011 NOR, 001100 XOR, 001101 XNOR: alu_a = R[rs1], alu_b = R[rs2]. EXEC 1 cycle; WB_LO -> rd1.
  - 001110 NOT: alu_a = R[rs1]; WB_LO -> rd1.
  - 001111 SHL, 010000 SHR: alu_a = R[rs1]; shift amount = R[rs2][3:0]. WB_LO -> rd1.
  - 010001 NOP: IDLE->IDLE, no side effects.
  - Other opcodes: illegal_op=1 for 1 cycle (T+1); no rf/dmem activity; remain IDLE.
- Register reads: port A = rs1, port B = rs2, presented in READ; operands are sampled in EXEC.
- alu_op = op[3:0] + 4 for op in 000100..010000 (a fixed mapping), held stable throughout EXEC.
- ADD timing: accept T, READ T+1, EXEC T+2, rf_we T+3 (rd1), rf_we T+4 (rd2), instr_ready=1 at T+5.
- rf_we is exactly 1 cycle per write. rd1==rd2: the WB_HI value wins (last write).
- dmem_req holds until dmem_ack. An ack coinciding with the first req cycle is valid. There is no timeout. An ack arriving while not in MEM is ignored.
- Register 0 gets no special treatment.

Optional Feature:
ALU_CTRL_PERF_EN
- Defined: adds outputs retired_cnt[31:0] and stall_cnt[31:0].
  - retired_cnt increments on each return to IDLE from a legal instruction, including NOP.
  - stall_cnt increments each MEM cycle with dmem_ack=0, and each EXEC cycle after the first.
  - Both wrap at 2^32, reset to 0 asynchronously, and stall_cnt is unaffected by illegal ops.
- Undefined: no counters and no ports.

Test Plan:
- LDI rd2=3, imm=0xBEEF -> rf_we at T+1, waddr=3, wdata=0xBEEF; instr_ready=1 at T+2.
- ADD R1=0xFFFF, R2=0x0001, rd1=4, rd2=5 -> R4=0x0000 at T+3, R5=0x0001 at T+4.
- MUL 0x1234*0x0100, MUL_LAT=4 -> mul_start one cycle; R[rd1]=0x3400, R[rd2]=0x0012; total 8 cycles to ready.
- LD addr 0x2A, ack delayed 3 cycles, rdata=0x5A5A -> dmem_req held 4 cycles, R[rd2]=0x5A5A; ST similarly drives dmem_we=1, no rf_we.
- Opcode 111111 -> illegal_op single pulse, no rf_we/dmem_req, next instr accepted at T+1.
- rst_n low during MUL EXEC -> all outputs 0 asynchronously, no write-back, IDLE after release; with ALU_CTRL_PERF_EN, retired_cnt=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: non-pipelined issue sequencer between the instruction
// source and the execute datapath (register file, ALU, multiplier, data
// memory). One instruction is in flight at a time.
// Optional build macro: ALU_CTRL_PERF_EN adds retired/stall counters.
module alu_issue_ctrl #(
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 4,
  parameter int AW      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [4:0]          rf_raddr_a,
  output logic [4:0]          rf_raddr_b,
  input  logic [DATA_W-1:0]   rf_rdata_a,
  input  logic [DATA_W-1:0]   rf_rdata_b,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [3:0]          alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                mul_start,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [AW-1:0]       dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_ack,
  output logic                busy,
  output logic                illegal_op
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [31:0]         retired_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB_LO, WB_HI} state_t;

  localparam logic [5:0] OP_LDI = 6'd0,  OP_MOV = 6'd1,  OP_LD  = 6'd2;
  localparam logic [5:0] OP_ST  = 6'd3,  OP_ADD = 6'd4,  OP_SUB = 6'd5;
  localparam logic [5:0] OP_NEG = 6'd6,  OP_MUL = 6'd7,  OP_NOT = 6'd14;
  localparam logic [5:0] OP_SHL = 6'd15, OP_SHR = 6'd16, OP_NOP = 6'd17;

  state_t              state_q;
  logic [15:0]         instrHi_q;
  logic [5:0]          opQ;
  logic [5:0]          inOp;
  logic                rfWe_q, mulStart_q, dmemReq_q, dmemWe_q, illegal_q;
  logic [4:0]          raddrA_q, raddrB_q, waddr_q;
  logic [DATA_W-1:0]   wdata_q, hi_q;
  logic [3:0]          aluOp_q;
  logic [AW-1:0]       dmemAddr_q;
  logic [7:0]          execCnt_q;
  logic                execDone;
  logic                hasHi;
`ifdef ALU_CTRL_PERF_EN
  logic [31:0]         retired_q, stall_q;
`endif

  // Only the upper half of the instruction is needed after acceptance
  // (opcode, rd2, rd1, store address); source fields are consumed at accept.
  assign opQ      = instrHi_q[15:10];
  assign inOp     = instr[31:26];
  assign hasHi    = (opQ == OP_ADD) || (opQ == OP_SUB) || (opQ == OP_MUL);
  assign execDone = (opQ != OP_MUL) || (execCnt_q == 8'(MUL_LAT - 1));

  // Operands come straight from the register file while in EXEC; the read
  // addresses are held so the data stays valid for the whole EXEC phase.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (state_q == EXEC) begin
      alu_a = rf_rdata_a;
      if (opQ == OP_NEG || opQ == OP_NOT)
        alu_b = '0;
      else if (opQ == OP_SHL || opQ == OP_SHR)
        alu_b = {{(DATA_W-4){1'b0}}, rf_rdata_b[3:0]};
      else
        alu_b = rf_rdata_b;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rf_we       = rfWe_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = (state_q == WB_LO && opQ == OP_MOV) ? rf_rdata_b : wdata_q;
  assign rf_raddr_a  = raddrA_q;
  assign rf_raddr_b  = raddrB_q;
  assign alu_op      = aluOp_q;
  assign mul_start   = mulStart_q;
  assign dmem_req    = dmemReq_q;
  assign dmem_we     = dmemWe_q;
  assign dmem_addr   = dmemAddr_q;
  assign dmem_wdata  = (state_q == MEM && dmemWe_q) ? rf_rdata_b : '0;
  assign illegal_op  = illegal_q;
`ifdef ALU_CTRL_PERF_EN
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

  // Main sequencer: state plus all registered control outputs; single-cycle
  // strobes (rf_we, mul_start, illegal_op) default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instrHi_q  <= '0;
      rfWe_q     <= 1'b0;
      mulStart_q <= 1'b0;
      dmemReq_q  <= 1'b0;
      dmemWe_q   <= 1'b0;
      illegal_q  <= 1'b0;
      raddrA_q   <= '0;
      raddrB_q   <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hi_q       <= '0;
      aluOp_q    <= '0;
      dmemAddr_q <= '0;
      execCnt_q  <= '0;
`ifdef ALU_CTRL_PERF_EN
      retired_q  <= '0;
      stall_q    <= '0;
`endif
    end else begin
      rfWe_q     <= 1'b0;
      mulStart_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instrHi_q <= instr[31:16];
            if (inOp == OP_LDI) begin
              rfWe_q  <= 1'b1;
              waddr_q <= instr[25:21];
              wdata_q <= instr[DATA_W-1:0];
              state_q <= WB_LO;
            end else if (inOp == OP_MOV || inOp == OP_ST) begin
              raddrB_q <= instr[4:0];
              state_q  <= READ;
            end else if (inOp == OP_LD) begin
              dmemReq_q  <= 1'b1;
              dmemWe_q   <= 1'b0;
              dmemAddr_q <= AW'(instr[7:0]);
              state_q    <= MEM;
            end else if (inOp >= OP_ADD && inOp <= OP_SHR) begin
              raddrA_q <= instr[4:0];
              raddrB_q <= instr[9:5];
              state_q  <= READ;
            end else if (inOp == OP_NOP) begin
`ifdef ALU_CTRL_PERF_EN
              retired_q <= retired_q + 32'd1;
`endif
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (opQ == OP_MOV) begin
            rfWe_q  <= 1'b1;
            waddr_q <= instrHi_q[9:5];
            state_q <= WB_LO;
          end else if (opQ == OP_ST) begin
            dmemReq_q  <= 1'b1;
            dmemWe_q   <= 1'b1;
            dmemAddr_q <= AW'(instrHi_q[9:2]);
            state_q    <= MEM;
          end else begin
            aluOp_q    <= opQ[3:0] + 4'd4;
            mulStart_q <= (opQ == OP_MUL);
            execCnt_q  <= '0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (execDone) begin
            rfWe_q  <= 1'b1;
            waddr_q <= instrHi_q[4:0];
            wdata_q <= alu_result[DATA_W-1:0];
            hi_q    <= (opQ == OP_MUL) ? alu_result[2*DATA_W-1:DATA_W]
                                       : {{(DATA_W-1){1'b0}}, alu_result[DATA_W]};
            aluOp_q <= '0;
            state_q <= WB_LO;
          end else begin
            execCnt_q <= execCnt_q + 8'd1;
          end
`ifdef ALU_CTRL_PERF_EN
          if (execCnt_q != 8'd0)
            stall_q <= stall_q + 32'd1;
`endif
        end
        MEM: begin
          if (dmem_ack) begin
            dmemReq_q  <= 1'b0;
            dmemWe_q   <= 1'b0;
            dmemAddr_q <= '0;
            if (dmemWe_q) begin
              state_q <= IDLE;
`ifdef ALU_CTRL_PERF_EN
              retired_q <= retired_q + 32'd1;
`endif
            end else begin
              rfWe_q  <= 1'b1;
              waddr_q <= instrHi_q[9:5];
              wdata_q <= dmem_rdata;
              state_q <= WB_LO;
            end
          end else begin
`ifdef ALU_CTRL_PERF_EN
            stall_q <= stall_q + 32'd1;
`endif
          end
        end
        WB_LO: begin
          if (hasHi) begin
            rfWe_q  <= 1'b1;
            waddr_q <= instrHi_q[9:5];
            wdata_q <= hi_q;
            state_q <= WB_HI;
          end else begin
            state_q <= IDLE;
`ifdef ALU_CTRL_PERF_EN
            retired_q <= retired_q + 32'd1;
`endif
          end
        end
        WB_HI: begin
          state_q <= IDLE;
`ifdef ALU_CTRL_PERF_EN
          retired_q <= retired_q + 32'd1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed-vector bench for alu_issue_ctrl with a
// synchronous-read register file, a behavioural ALU and a hand-driven
// data memory.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [31:0] alu_result;
  logic        mul_start, dmem_req, dmem_we;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        busy, illegal_op;

  logic [15:0] regs [32] = '{default: 16'h0000};
  int          vectors = 0;
  int          miscompares = 0;
  int          weCount = 0;

  alu_issue_ctrl #(.DATA_W(16), .MUL_LAT(4), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .mul_start(mul_start),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .busy(busy), .illegal_op(illegal_op)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Register file: synchronous read (data one cycle after address) and write
  always @(posedge clk) begin
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
    if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  // Count every write strobe so aborted instructions can be caught writing
  always @(posedge clk) if (rf_we) weCount <= weCount + 1;

  // Behavioural ALU/multiplier indexed by the controller's op select
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd8:  alu_result = {15'd0, {1'b0, alu_a} + {1'b0, alu_b}};
      4'd9:  alu_result = {15'd0, {1'b0, alu_a} - {1'b0, alu_b}};
      4'd10: alu_result = {16'd0, 16'd0 - alu_a};
      4'd11: alu_result = {16'd0, alu_a} * {16'd0, alu_b};
      4'd12: alu_result = {16'd0, alu_a & alu_b};
      4'd13: alu_result = {16'd0, alu_a | alu_b};
      4'd14: alu_result = {16'd0, ~(alu_a & alu_b)};
      4'd15: alu_result = {16'd0, ~(alu_a | alu_b)};
      4'd0:  alu_result = {16'd0, alu_a ^ alu_b};
      4'd1:  alu_result = {16'd0, ~(alu_a ^ alu_b)};
      4'd2:  alu_result = {16'd0, ~alu_a};
      4'd3:  alu_result = {16'd0, alu_a << alu_b[3:0]};
      4'd4:  alu_result = {16'd0, alu_a >> alu_b[3:0]};
      default: alu_result = '0;
    endcase
  end

  // Single comparison point: counts every vector and reports a miscompare
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Present one instruction for exactly one rising edge; returns at the
  // falling edge of the first cycle after acceptance (T+1)
  task automatic applyStimulus(input logic [31:0] word);
    @(negedge clk);
    instr       = word;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int c = 0;
    while (!instr_ready && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput(tag, {31'd0, instr_ready}, 32'd1);
  endtask

  function automatic logic [31:0] mkR(input logic [5:0] op, input logic [4:0] rd2,
                                      input logic [4:0] rd1, input logic [4:0] rs2,
                                      input logic [4:0] rs1);
    return {op, rd2, rd1, 6'd0, rs2, rs1};
  endfunction

  function automatic logic [31:0] mkLdi(input logic [4:0] rd2, input logic [15:0] imm);
    return {6'd0, rd2, 5'd0, imm};
  endfunction

  // Write-strobe snapshot: enable, address and data together
  task automatic checkWrite(input string tag, input logic [4:0] addr, input logic [15:0] data);
    checkOutput({tag, "_we"}, {31'd0, rf_we}, 32'd1);
    checkOutput({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, addr});
    checkOutput({tag, "_wdata"}, {16'd0, rf_wdata}, {16'd0, data});
  endtask

  initial begin : main
    int savedWe;
    $display("[TB] start");
    // Reset state
    step(2);
    checkOutput("rst_ready", {31'd0, instr_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ctrl", {28'd0, rf_we, dmem_req, mul_start, illegal_op}, 32'd0);
    checkOutput("rst_aluop", {28'd0, alu_op}, 32'd0);
    rst_n = 1'b1;

    // LDI R3 = 0xBEEF: write at T+1, ready at T+2
    applyStimulus(mkLdi(5'd3, 16'hBEEF));
    checkWrite("ldi", 5'd3, 16'hBEEF);
    checkOutput("ldi_busy", {31'd0, instr_ready}, 32'd0);
    step(1);
    checkOutput("ldi_ready", {31'd0, instr_ready}, 32'd1);
    checkOutput("ldi_we_off", {31'd0, rf_we}, 32'd0);

    // Operand preloads
    applyStimulus(mkLdi(5'd1, 16'hFFFF)); waitIdle("pre1", 5);
    applyStimulus(mkLdi(5'd2, 16'h0001)); waitIdle("pre2", 5);
    applyStimulus(mkLdi(5'd6, 16'h1234)); waitIdle("pre6", 5);
    applyStimulus(mkLdi(5'd7, 16'h0100)); waitIdle("pre7", 5);

    // ADD R1+R2 -> R4 = 0x0000, R5 = carry 1
    applyStimulus(mkR(6'd4, 5'd5, 5'd4, 5'd2, 5'd1));
    checkOutput("add_raddr", {22'd0, rf_raddr_a, rf_raddr_b}, {22'd0, 5'd1, 5'd2});
    step(1);
    checkOutput("add_aluop", {28'd0, alu_op}, 32'd8);
    checkOutput("add_ops", {alu_a, alu_b}, 32'hFFFF_0001);
    step(1);
    checkWrite("add_lo", 5'd4, 16'h0000);
    step(1);
    checkWrite("add_hi", 5'd5, 16'h0001);
    step(1);
    checkOutput("add_ready", {31'd0, instr_ready}, 32'd1);

    // MUL R6*R7 -> R8 = 0x3400, R9 = 0x0012; ready 8 cycles after accept
    applyStimulus(mkR(6'd7, 5'd9, 5'd8, 5'd7, 5'd6));
    checkOutput("mul_start_read", {31'd0, mul_start}, 32'd0);
    step(1);
    checkOutput("mul_start_e1", {31'd0, mul_start}, 32'd1);
    checkOutput("mul_aluop", {28'd0, alu_op}, 32'd11);
    step(1);
    checkOutput("mul_start_e2", {31'd0, mul_start}, 32'd0);
    step(2);
    checkOutput("mul_no_early_we", {30'd0, rf_we, busy}, 32'd1);
    step(1);
    checkWrite("mul_lo", 5'd8, 16'h3400);
    step(1);
    checkWrite("mul_hi", 5'd9, 16'h0012);
    step(1);
    checkOutput("mul_ready", {31'd0, instr_ready}, 32'd1);

    // SUB R2-R1 = 0x0002 with borrow
    applyStimulus(mkR(6'd5, 5'd11, 5'd10, 5'd1, 5'd2));
    step(2);
    checkWrite("sub_lo", 5'd10, 16'h0002);
    step(1);
    checkWrite("sub_hi", 5'd11, 16'h0001);
    waitIdle("sub_idle", 3);

    // XOR, SHL, NEG: single write-back only
    applyStimulus(mkR(6'd12, 5'd0, 5'd12, 5'd7, 5'd6));
    step(2);
    checkWrite("xor", 5'd12, 16'h1334);
    step(1);
    checkOutput("xor_single_wb", {30'd0, rf_we, instr_ready}, 32'd1);
    applyStimulus(mkR(6'd15, 5'd0, 5'd13, 5'd2, 5'd6));
    step(2);
    checkWrite("shl", 5'd13, 16'h2468);
    waitIdle("shl_idle", 3);
    applyStimulus(mkR(6'd6, 5'd0, 5'd14, 5'd0, 5'd2));
    step(2);
    checkWrite("neg", 5'd14, 16'hFFFF);
    waitIdle("neg_idle", 3);

    // MOV R15 <= R3
    applyStimulus(mkR(6'd1, 5'd15, 5'd0, 5'd0, 5'd3));
    checkOutput("mov_raddr_b", {27'd0, rf_raddr_b}, 32'd3);
    step(1);
    checkWrite("mov", 5'd15, 16'hBEEF);
    waitIdle("mov_idle", 3);

    // LD 0x2A with ack delayed three cycles: req held four cycles
    applyStimulus({6'd2, 5'd16, 13'd0, 8'h2A});
    checkOutput("ld_req1", {23'd0, dmem_req, dmem_we, dmem_addr}, {23'd0, 1'b1, 1'b0, 8'h2A});
    step(1);
    checkOutput("ld_req2", {31'd0, dmem_req}, 32'd1);
    step(1);
    checkOutput("ld_req3", {31'd0, dmem_req}, 32'd1);
    step(1);
    checkOutput("ld_req4", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1;
    dmem_rdata = 16'h5A5A;
    step(1);
    dmem_ack = 1'b0;
    checkOutput("ld_req_drop", {31'd0, dmem_req}, 32'd0);
    checkWrite("ld", 5'd16, 16'h5A5A);
    waitIdle("ld_idle", 3);

    // ST R3 -> 0x55 with ack on the first request cycle
    savedWe = weCount;
    applyStimulus({6'd3, 8'h55, 13'd0, 5'd3});
    checkOutput("st_noreq_read", {31'd0, dmem_req}, 32'd0);
    step(1);
    checkOutput("st_req", {23'd0, dmem_req, dmem_we, dmem_addr}, {23'd0, 1'b1, 1'b1, 8'h55});
    checkOutput("st_wdata", {16'd0, dmem_wdata}, 32'h0000_BEEF);
    dmem_ack = 1'b1;
    step(1);
    dmem_ack = 1'b0;
    checkOutput("st_done", {30'd0, dmem_req, instr_ready}, 32'd1);
    checkOutput("st_no_rf_we", weCount, savedWe);

    // Stray ack while idle is ignored
    dmem_ack = 1'b1;
    step(1);
    dmem_ack = 1'b0;
    checkOutput("stray_ack", {29'd0, busy, rf_we, dmem_req}, 32'd0);

    // NOP: no side effects
    savedWe = weCount;
    applyStimulus({6'd17, 26'd0});
    checkOutput("nop_idle", {29'd0, busy, dmem_req, illegal_op}, 32'd0);
    checkOutput("nop_no_we", weCount, savedWe);

    // Illegal opcode: one-cycle pulse, next instruction accepted at T+1
    applyStimulus({6'h3F, 26'd0});
    checkOutput("ill_pulse", {28'd0, illegal_op, rf_we, dmem_req, instr_ready}, 32'b1001);
    instr = mkLdi(5'd17, 16'h00A5);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput("ill_pulse_end", {31'd0, illegal_op}, 32'd0);
    checkWrite("ill_next", 5'd17, 16'h00A5);
    waitIdle("ill_idle", 3);

    // Reset asserted during MUL EXEC aborts with no write-back
    savedWe = weCount;
    applyStimulus(mkR(6'd7, 5'd21, 5'd20, 5'd7, 5'd6));
    step(2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_idle", {30'd0, busy, instr_ready}, 32'd1);
    checkOutput("abort_outs", {28'd0, rf_we, mul_start, dmem_req, illegal_op}, 32'd0);
    checkOutput("abort_aluop", {28'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    checkOutput("abort_no_we", weCount, savedWe);
    checkOutput("abort_regs", {regs[20], regs[21]}, 32'd0);
    checkOutput("abort_ready", {31'd0, instr_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
